// File: rtl/div_unit.sv
// div_unit -- multi-cycle divide sequencer for the EX stage.
//
// Runs DIV (signed) and DIVU (unsigned) as a DATA_WIDTH-iteration radix-2
// restoring division on operand magnitudes. Signs are restored when the
// result is registered. While the divide runs, the unit holds the pipeline.
// quotient/remainder are then presented with a one-cycle done pulse, so EX
// can write them to LO/HI.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      EX holds a DIV/DIVU (level, held while stalled)
//   is_signed  1 = DIV, 0 = DIVU
//   dividend   rs operand, sampled at acceptance
//   divisor    rt operand, sampled at acceptance
//   flush      cancels any operation; wins over start
//   stall_req  combinational pipeline-hold request
//   busy       registered, FSM in RUN or DONE
//   done       registered one-cycle result-valid pulse
//   quotient   registered result for LO
//   remainder  registered result for HI
module div_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  is_signed,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   input  logic                  flush,
   output logic                  stall_req,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q;
   logic [DATA_WIDTH-1:0] rem_q, quo_q, dvs_q;
   logic                  q_neg_q, r_neg_q;

   logic                  accept, div_zero, last, trial_ok;
   logic [DATA_WIDTH+1:0] trial;
   logic [DATA_WIDTH-1:0] rem_step, quo_step;

   // Two's complement negation truncated to DATA_WIDTH, so -min_int wraps
   // back to min_int.
   function automatic logic [DATA_WIDTH-1:0] neg_if(input logic [DATA_WIDTH-1:0] v,
                                                    input logic n);
      return n ? (~v + ONE) : v;
   endfunction

   assign accept   = (state_q == IDLE) && start && !flush;
   assign div_zero = (divisor == '0);
   assign last     = (cnt_q == CNT_W'(1));

   // One restoring step. The shifted partial remainder can reach
   // 2*divisor-1, which needs DATA_WIDTH+1 bits when the divisor has its MSB
   // set, so the trial uses one more bit again to hold the borrow.
   assign trial    = {1'b0, rem_q, quo_q[DATA_WIDTH-1]} - {2'b00, dvs_q};
   assign trial_ok = !trial[DATA_WIDTH+1];
   assign rem_step = trial_ok ? trial[DATA_WIDTH-1:0]
                              : {rem_q[DATA_WIDTH-2:0], quo_q[DATA_WIDTH-1]};
   assign quo_step = {quo_q[DATA_WIDTH-2:0], trial_ok};

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = div_zero ? DONE : RUN;
         RUN:     if (last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   assign stall_req = accept || ((state_q == RUN) && !flush);

   // Control and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         q_neg_q   <= 1'b0;
         r_neg_q   <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         state_q <= state_d;
         done    <= (state_d == DONE);
         busy    <= (state_d != IDLE);
         if (accept) begin
            cnt_q   <= CNT_W'(DATA_WIDTH);
            q_neg_q <= is_signed && (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
            r_neg_q <= is_signed && dividend[DATA_WIDTH-1];
            if (div_zero) begin
               quotient  <= '1;
               remainder <= dividend;
            end
         end else if (state_q == RUN) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (last && !flush) begin
               quotient  <= neg_if(quo_step, q_neg_q);
               remainder <= neg_if(rem_step, r_neg_q);
            end
         end
      end
   end

   // Iteration datapath; the quotient shifts in where the dividend was.
   always_ff @(posedge clk) begin
      if (accept) begin
         rem_q <= '0;
         quo_q <= neg_if(dividend, is_signed && dividend[DATA_WIDTH-1]);
         dvs_q <= neg_if(divisor, is_signed && divisor[DATA_WIDTH-1]);
      end else if (state_q == RUN) begin
         rem_q <= rem_step;
         quo_q <= quo_step;
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit -- scoreboard bench for div_unit (DATA_WIDTH = 32).
// Stimulus pushes the hand-computed {quotient, remainder} when it issues a
// divide; a monitor pops and compares on every done pulse.
module tb_div_unit;

   logic        clk, rst, start, is_signed, flush;
   logic [31:0] dividend, divisor;
   logic        stall_req, busy, done;
   logic [31:0] quotient, remainder;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];

   div_unit #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
      .dividend(dividend), .divisor(divisor), .flush(flush),
      .stall_req(stall_req), .busy(busy), .done(done),
      .quotient(quotient), .remainder(remainder)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Counts cycles from the current negedge (cycle 0) until done is seen.
   task automatic wait_done(output int cyc, output int stalls);
      logic overlap;
      overlap = 1'b0;
      stalls  = 0;
      cyc     = 0;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (stall_req && done) overlap = 1'b1;
         if (stall_req) stalls++;
         if (done) break;
         @(negedge clk);
         cyc++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done after %0d cycles, expected one", cyc);
      end
      check("done_stall_overlap", 32'(overlap), 32'd0);
   endtask

   task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input int exp_cyc, input int exp_stall);
      int cyc, st;
      @(negedge clk);
      is_signed = sgn;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      exp_q.push_back({eq, er});
      wait_done(cyc, st);
      check("done_cycle", 32'(cyc), 32'(exp_cyc));
      check("stall_cycles", 32'(st), 32'(exp_stall));
      @(negedge clk);
      start = 1'b0;
   endtask

   // Monitor: compare results against the scoreboard on each done pulse.
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 with q=0x%08h r=0x%08h, expected no pulse",
                        quotient, remainder);
            end else begin
               e = exp_q.pop_front();
               check("quotient", quotient, e[63:32]);
               check("remainder", remainder, e[31:0]);
            end
         end
      end
   end

   initial begin
      int c1, c2, s1, s2;
      rst = 1'b1; start = 1'b0; is_signed = 1'b0; flush = 1'b0;
      dividend = '0; divisor = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_quotient", quotient, 32'd0);
      check("rst_remainder", remainder, 32'd0);
      rst = 1'b0;
      #1;
      check("idle_stall", 32'(stall_req), 32'd0);

      run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 33);
      run_op(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, 33);
      run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 33, 33);
      run_op(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33, 33);
      run_op(1'b0, 32'hFFFFFFFF, 32'h80000000, 32'd1, 32'h7FFFFFFF, 33, 33);
      run_op(1'b0, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1, 1);

      // Flush in RUN cycle 10, then a new divide on the following cycle.
      @(negedge clk);
      is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
      for (int c = 1; c <= 10; c++) @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush_stall", 32'(stall_req), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      dividend = 32'hFFFFFFFF; divisor = 32'd16;
      #1;
      check("flush_busy", 32'(busy), 32'd0);
      check("flush_keep_q", quotient, 32'hFFFFFFFF);
      check("flush_keep_r", remainder, 32'h1234);
      exp_q.push_back({32'h0FFFFFFF, 32'h0000000F});
      wait_done(c1, s1);
      check("post_flush_cycle", 32'(c1), 32'd33);
      check("post_flush_stalls", 32'(s1), 32'd33);
      @(negedge clk);
      start = 1'b0;

      // Reset in RUN cycle 20.
      @(negedge clk);
      is_signed = 1'b0; dividend = 32'd77; divisor = 32'd3; start = 1'b1;
      for (int c = 1; c <= 20; c++) @(negedge clk);
      rst = 1'b1; start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_quotient", quotient, 32'd0);
      check("mid_rst_remainder", remainder, 32'd0);
      check("mid_rst_stall", 32'(stall_req), 32'd0);

      // Back-to-back with start held through DONE.
      @(negedge clk);
      is_signed = 1'b0; dividend = 32'd9; divisor = 32'd3; start = 1'b1;
      exp_q.push_back({32'd3, 32'd0});
      wait_done(c1, s1);
      check("b2b_first_cycle", 32'(c1), 32'd33);
      dividend = 32'd10; divisor = 32'd4;
      exp_q.push_back({32'd2, 32'd2});
      @(negedge clk);
      wait_done(c2, s2);
      check("b2b_gap", 32'(c2 + 1), 32'd34);
      check("b2b_second_stalls", 32'(s2), 32'd33);
      @(negedge clk);
      start = 1'b0;

      repeat (40) @(negedge clk);
      check("pending_results", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
